rr_reg_arbiter: RTL and testbench
=================================

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters; the block SHALL support only the value 4.
REQ-002 Parameter WIDTH, default 8, is the data width of the shared register.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  level request per requester; bit i belongs to requester i.
REQ-006 wdata  input  N_REQ*WIDTH  write data; requester i owns bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  N_REQ  one-hot grant, registered.
REQ-008 ack  output  1  one-cycle pulse when the granted write has landed in q.
REQ-009 busy  output  1  high while a transfer is in progress (GRANT or DONE state).
REQ-010 q  output  WIDTH  shared register contents.
REQ-011 last_id  output  2  index of the most recently completed requester.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and DONE.
REQ-013 IDLE, req==0: the FSM SHALL stay in IDLE with gnt=0 and busy=0.
REQ-014 IDLE, req!=0: on the rising edge, the FSM SHALL pick the winner as the first set req bit searching from (ptr+1) mod 4 upward with wrap, set gnt to that one-hot value, set busy=1, latch the winner index sel, and go to GRANT.
REQ-015 GRANT: on the rising edge, q SHALL load wdata[sel], ack SHALL go 1 and the FSM SHALL go to DONE; gnt SHALL stay unchanged.
REQ-016 DONE: on the rising edge, ack, gnt and busy SHALL go 0, last_id and ptr SHALL load sel, and the FSM SHALL return to IDLE.
REQ-017 Latency: gnt is high for exactly 2 cycles; ack is high for exactly 1 cycle, coinciding with the second gnt cycle; the new q value is visible in that same cycle.
REQ-018 Throughput SHALL be one write per 3 cycles; the minimum spacing between consecutive gnt assertions is 1 idle cycle.
REQ-019 Once GRANT is entered, the write SHALL complete even if req[sel] drops during GRANT; wdata is sampled only in GRANT.
REQ-020 A requester that holds req after its ack SHALL be re-arbitrated with lowest priority (round-robin); it SHALL win again only if no other req bit is set.
REQ-021 req changes while the FSM is in GRANT or DONE SHALL have no effect until the next IDLE evaluation.
REQ-022 q SHALL change only in GRANT and otherwise hold its value.
REQ-023 gnt SHALL never have more than one bit set.

Reset
REQ-024 reset_n=0 SHALL immediately and asynchronously force: state=IDLE, gnt=0, ack=0, busy=0, q=0, last_id=0, ptr=3 (requester 0 has top priority after reset).
REQ-025 Reset asserted in GRANT or DONE SHALL abort the transfer with no ack, and q SHALL be 0.
REQ-026 Reset deassertion SHALL be sampled like any input; the first arbitration occurs on the first rising edge with reset_n=1.

Structure
REQ-027 State encodings (IDLE=2'b00, GRANT=2'b01, DONE=2'b10) and the N_REQ and WIDTH defaults SHALL live in a shared package/include, rr_arb_pkg.
REQ-028 q SHALL be implemented by one sub-module, _register_r: a WIDTH-bit register with enable and async active-low reset, built from _dff_r cells.
REQ-029 Round-robin selection SHALL be a combinational function of req and ptr, inside rr_reg_arbiter.

Verification
REQ-030 Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, ack=0, busy=0, q=0, last_id=0 throughout.
REQ-031 Single request: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 for 2 cycles; ack in the 2nd gnt cycle; q=8'hA5; last_id=2.
REQ-032 Rotation: req=4'b1111 held after reset -> grant order 0,1,2,3,0 with 1 idle cycle between grants.
REQ-033 Fairness: req=4'b0011 held, ptr=0 -> grants alternate 1,0,1,0.
REQ-034 Withdrawal: grant requester 3, drop req[3] in GRANT -> write completes, ack pulses, q=wdata[3].
REQ-035 Mid-op reset: pull reset_n low in DONE -> outputs clear immediately; after release with req=4'b1000, requester 3 is granted and last_id=3 after DONE.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin register arbiter.
//   N_REQ_DEF : default number of requesters (the arbiter supports only 4)
//   WIDTH_DEF : default width of the shared register
//   state_t   : arbiter FSM states with fixed encodings
//   req_id_t  : requester index type
package rr_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ID_W      = 2;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/rr_reg_arbiter_register_r.sv
// Enabled register with asynchronous active-low reset, built from per-bit
// flip-flop cells.
//   rr_reg_arbiter_dff_r      : one bit; loads d when en=1, clears on reset_n=0
//   rr_reg_arbiter_register_r : WIDTH copies of the cell sharing clk/reset_n/en
//     clk     in  1      rising-edge clock
//     reset_n in  1      asynchronous active-low reset (clears to 0)
//     en      in  1      load enable
//     d       in  WIDTH  data to load
//     q       out WIDTH  stored value
module rr_reg_arbiter_dff_r (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);

  // NOTE: the shared data register is reset like any control state, so an
  // aborted transfer can never leave stale data visible after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module rr_reg_arbiter_register_r #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    rr_reg_arbiter_dff_r u_dff (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .d       (d[b]),
      .q       (q[b])
    );
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding one shared register.
// Each transfer takes three cycles: IDLE (arbitrate) -> GRANT (write q)
// -> DONE (retire, rotate priority). The winner of a transfer becomes the
// lowest-priority requester for the next arbitration.
//   clk     in  1            rising-edge clock
//   reset_n in  1            asynchronous active-low reset
//   req     in  N_REQ        level requests, bit i = requester i
//   wdata   in  N_REQ*WIDTH  write data, requester i owns [i*WIDTH +: WIDTH]
//   gnt     out N_REQ        registered one-hot grant (high in GRANT and DONE)
//   ack     out 1            one-cycle pulse when the write has landed in q
//   busy    out 1            high while in GRANT or DONE
//   q       out WIDTH        shared register contents
//   last_id out 2            index of the most recently completed requester
// Only N_REQ = 4 is supported (requester indices are 2 bits wide).
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic [1:0]             last_id
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  req_id_t          sel_q, sel_d;
  req_id_t          ptr_q, ptr_d;
  req_id_t          last_id_q, last_id_d;
  logic             q_en;

  logic [WIDTH-1:0] wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_wdata
    assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set request bit at ptr+1, ptr+2, ... with wrap.
  // The 2-bit sum wraps naturally, and k = N_REQ revisits ptr itself last.
  logic    win_found;
  req_id_t win_idx;
  req_id_t cand;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr_q + req_id_t'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    last_id_d = last_id_q;
    q_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          sel_d          = win_idx;
        end
      end
      GRANT: begin
        // The write completes regardless of req; wdata is sampled only here.
        q_en    = 1'b1;
        ack_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ack_d     = 1'b0;
        gnt_d     = '0;
        busy_d    = 1'b0;
        last_id_d = sel_q;
        ptr_d     = sel_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= 2'd3;  // requester 0 has top priority after reset
      last_id_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      last_id_q <= last_id_d;
    end
  end

  rr_reg_arbiter_register_r #(
    .WIDTH (WIDTH)
  ) u_q_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (q_en),
    .d       (wdata_arr[sel_q]),
    .q       (q)
  );

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter: reset, rotation, fairness, single
// request, idle hold, withdrawal during GRANT and reset during DONE.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rr_reg_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   reset_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   ack;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [1:0]             last_id;

  int total = 0;
  int bad   = 0;

  rr_reg_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .q       (q),
    .last_id (last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int idx, input logic [7:0] val);
    wdata[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".gnt"},     32'(gnt),     32'h0);
    check({tag, ".ack"},     32'(ack),     32'h0);
    check({tag, ".busy"},    32'(busy),    32'h0);
    check({tag, ".q"},       32'(q),       32'h0);
    check({tag, ".last_id"}, 32'(last_id), 32'h0);
  endtask

  // Three cycles of one transfer, starting with the FSM in IDLE and the
  // expected winner already requesting.
  task automatic xfer(input string tag, input int id, input logic [7:0] data,
                      input int prev_last);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    step();
    check({tag, ".g1.gnt"},  32'(gnt),     32'(oh));
    check({tag, ".g1.ack"},  32'(ack),     32'h0);
    check({tag, ".g1.busy"}, 32'(busy),    32'h1);
    check({tag, ".g1.last"}, 32'(last_id), 32'(prev_last));
    step();
    check({tag, ".g2.gnt"},  32'(gnt),     32'(oh));
    check({tag, ".g2.ack"},  32'(ack),     32'h1);
    check({tag, ".g2.busy"}, 32'(busy),    32'h1);
    check({tag, ".g2.q"},    32'(q),       32'(data));
    step();
    check({tag, ".idle.gnt"},  32'(gnt),     32'h0);
    check({tag, ".idle.ack"},  32'(ack),     32'h0);
    check({tag, ".idle.busy"}, 32'(busy),    32'h0);
    check({tag, ".idle.last"}, 32'(last_id), 32'(id));
    check({tag, ".idle.q"},    32'(q),       32'(data));
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;
    wdata   = '0;
    set_w(0, 8'h10);
    set_w(1, 8'h21);
    set_w(2, 8'h32);
    set_w(3, 8'h43);

    // Reset held with all requests asserted: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      check_cleared("reset");
    end

    // Rotation with all requests held: 0,1,2,3,0.
    reset_n = 1'b1;
    xfer("rot0", 0, 8'h10, 0);
    xfer("rot1", 1, 8'h21, 0);
    xfer("rot2", 2, 8'h32, 1);
    xfer("rot3", 3, 8'h43, 2);
    xfer("rot4", 0, 8'h10, 3);

    // Fairness with ptr=0 and two requesters: 1,0,1,0.
    req = 4'b0011;
    xfer("fair1", 1, 8'h21, 0);
    xfer("fair0", 0, 8'h10, 1);
    xfer("fair1b", 1, 8'h21, 0);
    xfer("fair0b", 0, 8'h10, 1);

    // Single request, then the same requester alone wins again.
    req = 4'b0100;
    set_w(2, 8'hA5);
    xfer("single", 2, 8'hA5, 0);
    xfer("again", 2, 8'hA5, 2);

    // No requests: stay idle, q holds.
    req = 4'b0000;
    set_w(2, 8'h77);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold.gnt",  32'(gnt),  32'h0);
      check("hold.busy", 32'(busy), 32'h0);
      check("hold.q",    32'(q),    32'hA5);
    end

    // Withdrawal: requester 3 drops req in GRANT while requester 0 raises
    // it; the write still completes and the new request waits for IDLE.
    req = 4'b1000;
    set_w(3, 8'h5C);
    step();
    check("wd.g1.gnt",  32'(gnt),  32'h8);
    check("wd.g1.busy", 32'(busy), 32'h1);
    req = 4'b0001;
    step();
    check("wd.g2.gnt", 32'(gnt), 32'h8);
    check("wd.g2.ack", 32'(ack), 32'h1);
    check("wd.g2.q",   32'(q),   32'h5C);
    step();
    check("wd.idle.gnt",  32'(gnt),     32'h0);
    check("wd.idle.ack",  32'(ack),     32'h0);
    check("wd.idle.last", 32'(last_id), 32'h3);
    step();
    check("next.g1.gnt", 32'(gnt), 32'h1);
    step();
    check("next.g2.ack", 32'(ack), 32'h1);
    check("next.g2.q",   32'(q),   32'h10);

    // FSM is now in DONE: asynchronous reset clears outputs at once.
    reset_n = 1'b0;
    #1;
    check_cleared("midrst");
    req = 4'b1000;
    step();
    check_cleared("midrst.held");
    reset_n = 1'b1;
    xfer("postrst", 3, 8'h5C, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
